// File: rtl/multi_alarm_controller.sv
// Multi-channel alarm engine: NUM_ALARMS programmable HH:MM alarms compared against
// the running time, driving an IDLE / RINGING / SNOOZED machine with snooze limit and ring timeout.
module multi_alarm_controller #(
  parameter int NUM_ALARMS       = 4,
  parameter int IDX_W            = 2,
  parameter int SNOOZE_SEC       = 300,
  parameter int RING_TIMEOUT_SEC = 60,
  parameter int MAX_SNOOZE       = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tick_sec,
  input  logic                  adjust_mode,
  input  logic [4:0]            cur_hours,
  input  logic [5:0]            cur_minutes,
  input  logic [5:0]            cur_seconds,
  input  logic                  wr_en,
  input  logic [IDX_W-1:0]      wr_idx,
  input  logic [4:0]            wr_hours,
  input  logic [5:0]            wr_minutes,
  input  logic                  wr_arm,
  input  logic                  snooze,
  input  logic                  dismiss,
  output logic                  ring,
  output logic                  ring_blink,
  output logic [IDX_W-1:0]      ring_idx,
  output logic [NUM_ALARMS-1:0] armed_mask,
  output logic [1:0]            snooze_count,
  output logic                  busy
);

  localparam int RT_W = $clog2(RING_TIMEOUT_SEC + 1);
  localparam int SN_W = $clog2(SNOOZE_SEC + 1);
  localparam logic [RT_W-1:0]  RT_LAST = RT_W'(RING_TIMEOUT_SEC - 1);
  localparam logic [RT_W-1:0]  RT_MAX  = RT_W'(RING_TIMEOUT_SEC);
  localparam logic [SN_W-1:0]  SN_LOAD = SN_W'(SNOOZE_SEC);
  localparam logic [1:0]       SNZ_MAX = 2'(MAX_SNOOZE);
  localparam logic [IDX_W:0]   NUM_C   = (IDX_W + 1)'(NUM_ALARMS);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RINGING = 2'd1,
    SNOOZED = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [4:0]       alarm_hours   [NUM_ALARMS];
  logic [5:0]       alarm_minutes [NUM_ALARMS];

  logic [RT_W-1:0]  ring_timer, ring_timer_d;
  logic [SN_W-1:0]  snooze_timer, snooze_timer_d;
  logic             ring_d, ring_blink_d, busy_d;
  logic [IDX_W-1:0] ring_idx_d;
  logic [1:0]       snooze_count_d;

  logic             wr_ok;
  logic             disarm_active;
  logic             trig_hit;
  logic             trig_go;
  logic [IDX_W-1:0] trig_idx;
  logic             go_idle;

  // A write is taken only when every field is in range; otherwise it is dropped whole.
  assign wr_ok = wr_en && ({1'b0, wr_idx} < NUM_C) &&
                 (wr_hours <= 5'd23) && (wr_minutes <= 6'd59);

  assign disarm_active = wr_ok && !wr_arm && (wr_idx == ring_idx) && (state_q != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_ALARMS; i++) begin
        alarm_hours[i]   <= '0;
        alarm_minutes[i] <= '0;
      end
      armed_mask <= '0;
    end else if (wr_ok) begin
      alarm_hours[wr_idx]   <= wr_hours;
      alarm_minutes[wr_idx] <= wr_minutes;
      armed_mask[wr_idx]    <= wr_arm;
    end
  end

  // Scan from the top so the lowest matching channel is the one left standing.
  always_comb begin
    trig_hit = 1'b0;
    trig_idx = '0;
    for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
      if (armed_mask[i] && (alarm_hours[i] == cur_hours) &&
          (alarm_minutes[i] == cur_minutes)) begin
        trig_hit = 1'b1;
        trig_idx = IDX_W'(i);
      end
    end
  end

  assign trig_go = trig_hit && tick_sec && (cur_seconds == 6'd0) && !adjust_mode;

  always_comb begin
    state_d        = state_q;
    ring_d         = ring;
    ring_blink_d   = ring_blink;
    ring_idx_d     = ring_idx;
    snooze_count_d = snooze_count;
    ring_timer_d   = ring_timer;
    snooze_timer_d = snooze_timer;
    go_idle        = 1'b0;

    if (disarm_active) begin
      go_idle = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (trig_go) begin
            state_d        = RINGING;
            ring_d         = 1'b1;
            ring_blink_d   = 1'b1;
            ring_idx_d     = trig_idx;
            snooze_count_d = 2'd0;
            ring_timer_d   = '0;
          end
        end
        RINGING: begin
          if (dismiss) begin
            go_idle = 1'b1;
          end else if (snooze) begin
            if (snooze_count < SNZ_MAX) begin
              state_d        = SNOOZED;
              snooze_count_d = snooze_count + 2'd1;
              snooze_timer_d = SN_LOAD;
              ring_d         = 1'b0;
              ring_blink_d   = 1'b0;
            end else begin
              go_idle = 1'b1;
            end
          end else if (tick_sec) begin
            if (ring_timer == RT_LAST) begin
              go_idle = 1'b1;
            end else begin
              ring_blink_d = ~ring_blink;
              if (ring_timer != RT_MAX) ring_timer_d = ring_timer + RT_W'(1);
            end
          end
        end
        SNOOZED: begin
          if (dismiss) begin
            go_idle = 1'b1;
          end else if (tick_sec) begin
            if (snooze_timer == SN_W'(1)) begin
              state_d        = RINGING;
              ring_d         = 1'b1;
              ring_blink_d   = 1'b1;
              ring_timer_d   = '0;
              snooze_timer_d = '0;
            end else if (snooze_timer != '0) begin
              snooze_timer_d = snooze_timer - SN_W'(1);
            end
          end
        end
        default: go_idle = 1'b1;
      endcase
    end

    // ring_idx deliberately survives the return to IDLE.
    if (go_idle) begin
      state_d        = IDLE;
      ring_d         = 1'b0;
      ring_blink_d   = 1'b0;
      snooze_count_d = 2'd0;
      ring_timer_d   = '0;
      snooze_timer_d = '0;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      ring         <= 1'b0;
      ring_blink   <= 1'b0;
      ring_idx     <= '0;
      snooze_count <= 2'd0;
      ring_timer   <= '0;
      snooze_timer <= '0;
      busy         <= 1'b0;
    end else begin
      state_q      <= state_d;
      ring         <= ring_d;
      ring_blink   <= ring_blink_d;
      ring_idx     <= ring_idx_d;
      snooze_count <= snooze_count_d;
      ring_timer   <= ring_timer_d;
      snooze_timer <= snooze_timer_d;
      busy         <= busy_d;
    end
  end

endmodule

// File: tb/tb_multi_alarm_controller.sv
// Bench for multi_alarm_controller: directed scenarios plus randomized traffic,
// all checked against a behavioural model of the alarm rules.
module tb_multi_alarm_controller;

  localparam int NUM_ALARMS       = 4;
  localparam int IDX_W            = 2;
  localparam int SNOOZE_SEC       = 300;
  localparam int RING_TIMEOUT_SEC = 60;
  localparam int MAX_SNOOZE       = 3;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  tick_sec = 1'b0;
  logic                  adjust_mode = 1'b0;
  logic [4:0]            cur_hours = '0;
  logic [5:0]            cur_minutes = '0;
  logic [5:0]            cur_seconds = '0;
  logic                  wr_en = 1'b0;
  logic [IDX_W-1:0]      wr_idx = '0;
  logic [4:0]            wr_hours = '0;
  logic [5:0]            wr_minutes = '0;
  logic                  wr_arm = 1'b0;
  logic                  snooze = 1'b0;
  logic                  dismiss = 1'b0;
  logic                  ring;
  logic                  ring_blink;
  logic [IDX_W-1:0]      ring_idx;
  logic [NUM_ALARMS-1:0] armed_mask;
  logic [1:0]            snooze_count;
  logic                  busy;

  always #5 clk = ~clk;

  multi_alarm_controller #(
    .NUM_ALARMS(NUM_ALARMS), .IDX_W(IDX_W), .SNOOZE_SEC(SNOOZE_SEC),
    .RING_TIMEOUT_SEC(RING_TIMEOUT_SEC), .MAX_SNOOZE(MAX_SNOOZE)
  ) dut (
    .clk(clk), .rst(rst), .tick_sec(tick_sec), .adjust_mode(adjust_mode),
    .cur_hours(cur_hours), .cur_minutes(cur_minutes), .cur_seconds(cur_seconds),
    .wr_en(wr_en), .wr_idx(wr_idx), .wr_hours(wr_hours), .wr_minutes(wr_minutes),
    .wr_arm(wr_arm), .snooze(snooze), .dismiss(dismiss), .ring(ring),
    .ring_blink(ring_blink), .ring_idx(ring_idx), .armed_mask(armed_mask),
    .snooze_count(snooze_count), .busy(busy)
  );

  int asserts = 0;
  int errors  = 0;

  // Reference model: 0 = idle, 1 = ringing, 2 = snoozed
  int m_state, m_idx, m_cnt, m_rung, m_left;
  bit m_ring, m_blink;
  int m_h [NUM_ALARMS];
  int m_m [NUM_ALARMS];
  bit m_arm [NUM_ALARMS];

  wire [10:0] dut_vec = {ring, ring_blink, ring_idx, armed_mask, snooze_count, busy};

  function automatic logic [10:0] exp_vec();
    logic [NUM_ALARMS-1:0] am;
    for (int i = 0; i < NUM_ALARMS; i++) am[i] = m_arm[i];
    return {m_ring, m_blink, 2'(m_idx), am, 2'(m_cnt), (m_state != 0)};
  endfunction

  task automatic model_step();
    bit wr_ok, go_idle;
    int win;
    wr_ok = wr_en && (int'(wr_idx) < NUM_ALARMS) && (wr_hours <= 23) && (wr_minutes <= 59);
    if (rst) begin
      m_state = 0; m_ring = 0; m_blink = 0; m_idx = 0; m_cnt = 0; m_rung = 0; m_left = 0;
      for (int i = 0; i < NUM_ALARMS; i++) begin
        m_h[i] = 0; m_m[i] = 0; m_arm[i] = 0;
      end
      return;
    end
    go_idle = 0;
    if (wr_ok && !wr_arm && m_state != 0 && int'(wr_idx) == m_idx) begin
      go_idle = 1;
    end else if (m_state == 1) begin
      if (dismiss) go_idle = 1;
      else if (snooze) begin
        if (m_cnt < MAX_SNOOZE) begin
          m_state = 2; m_cnt++; m_left = SNOOZE_SEC; m_ring = 0; m_blink = 0;
        end else go_idle = 1;
      end else if (tick_sec) begin
        m_rung++;
        if (m_rung >= RING_TIMEOUT_SEC) go_idle = 1;
        else m_blink = !m_blink;
      end
    end else if (m_state == 2) begin
      if (dismiss) go_idle = 1;
      else if (tick_sec) begin
        m_left--;
        if (m_left == 0) begin
          m_state = 1; m_ring = 1; m_blink = 1; m_rung = 0;
        end
      end
    end else begin
      win = -1;
      if (tick_sec && cur_seconds == 0 && !adjust_mode)
        for (int i = NUM_ALARMS - 1; i >= 0; i--)
          if (m_arm[i] && m_h[i] == int'(cur_hours) && m_m[i] == int'(cur_minutes)) win = i;
      if (win >= 0) begin
        m_state = 1; m_ring = 1; m_blink = 1; m_idx = win; m_cnt = 0; m_rung = 0;
      end
    end
    if (go_idle) begin
      m_state = 0; m_ring = 0; m_blink = 0; m_cnt = 0;
    end
    if (wr_ok) begin
      m_h[int'(wr_idx)] = int'(wr_hours);
      m_m[int'(wr_idx)] = int'(wr_minutes);
      m_arm[int'(wr_idx)] = wr_arm;
    end
  endtask

  // One clock: model consumes the current inputs, DUT is sampled 1 ns after the edge.
  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    tick_sec = 1'b0; wr_en = 1'b0; snooze = 1'b0; dismiss = 1'b0;
  endtask

  task automatic do_write(input int idx, input int h, input int m, input bit arm);
    wr_en = 1'b1; wr_idx = IDX_W'(idx); wr_hours = 5'(h); wr_minutes = 6'(m); wr_arm = arm;
    step();
  endtask

  task automatic set_time(input int h, input int m, input int s);
    cur_hours = 5'(h); cur_minutes = 6'(m); cur_seconds = 6'(s);
  endtask

  task automatic do_tick();
    tick_sec = 1'b1;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    asserts++;
    if (dut_vec !== 11'd0) begin
      errors++; $display("FAIL reset_outputs: got %h want 000", dut_vec);
    end
    asserts++;
    if (dut_vec !== exp_vec()) begin
      errors++; $display("FAIL reset_model: got %h want %h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_trigger_basic();
    do_write(2, 7, 30, 1'b1);
    set_time(7, 30, 0);
    do_tick();
    asserts++;
    if (ring !== 1'b1 || ring_idx !== 2'd2 || ring_blink !== 1'b1 || busy !== 1'b1) begin
      errors++; $display("FAIL trig_basic: ring=%b idx=%0d blink=%b busy=%b want 1 2 1 1",
                         ring, ring_idx, ring_blink, busy);
    end
    set_time(7, 30, 1);
    do_tick();
    asserts++;
    if (ring_blink !== 1'b0) begin
      errors++; $display("FAIL blink_toggle1: got %b want 0", ring_blink);
    end
    do_tick();
    asserts++;
    if (ring_blink !== 1'b1 || dut_vec !== exp_vec()) begin
      errors++; $display("FAIL blink_toggle2: got %h want %h", dut_vec, exp_vec());
    end
    dismiss = 1'b1;
    step();
    asserts++;
    if (ring !== 1'b0 || busy !== 1'b0 || ring_idx !== 2'd2) begin
      errors++; $display("FAIL dismiss_basic: ring=%b busy=%b idx=%0d want 0 0 2", ring, busy, ring_idx);
    end
  endtask

  task automatic test_lowest_index();
    do_write(0, 6, 0, 1'b1);
    do_write(3, 6, 0, 1'b1);
    set_time(6, 0, 0);
    do_tick();
    asserts++;
    if (ring !== 1'b1 || ring_idx !== 2'd0) begin
      errors++; $display("FAIL lowest_idx: ring=%b idx=%0d want 1 0", ring, ring_idx);
    end
    dismiss = 1'b1;
    step();
    repeat (5) step();
    asserts++;
    if (ring !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL no_retrigger: ring=%b busy=%b want 0 0", ring, busy);
    end
    do_tick();
    dismiss = 1'b1; tick_sec = 1'b1;
    step();
    asserts++;
    if (busy !== 1'b0 || ring !== 1'b0 || dut_vec !== exp_vec()) begin
      errors++; $display("FAIL dismiss_vs_trigger: got %h want %h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_snooze();
    set_time(6, 0, 0);
    do_tick();
    set_time(6, 1, 5);
    for (int k = 1; k <= MAX_SNOOZE; k++) begin
      snooze = 1'b1;
      step();
      asserts++;
      if (ring !== 1'b0 || snooze_count !== 2'(k) || busy !== 1'b1) begin
        errors++; $display("FAIL snooze_enter%0d: ring=%b cnt=%0d busy=%b want 0 %0d 1",
                           k, ring, snooze_count, busy, k);
      end
      repeat (SNOOZE_SEC - 1) do_tick();
      asserts++;
      if (ring !== 1'b0 || busy !== 1'b1) begin
        errors++; $display("FAIL snooze_early%0d: ring=%b busy=%b want 0 1", k, ring, busy);
      end
      do_tick();
      asserts++;
      if (ring !== 1'b1 || ring_blink !== 1'b1 || snooze_count !== 2'(k)) begin
        errors++; $display("FAIL snooze_expire%0d: ring=%b blink=%b cnt=%0d want 1 1 %0d",
                           k, ring, ring_blink, snooze_count, k);
      end
    end
    snooze = 1'b1;
    step();
    asserts++;
    if (busy !== 1'b0 || ring !== 1'b0 || snooze_count !== 2'd0) begin
      errors++; $display("FAIL snooze_limit: busy=%b ring=%b cnt=%0d want 0 0 0", busy, ring, snooze_count);
    end
  endtask

  task automatic test_timeout();
    set_time(6, 0, 0);
    do_tick();
    set_time(6, 0, 1);
    repeat (RING_TIMEOUT_SEC - 1) do_tick();
    asserts++;
    if (ring !== 1'b1) begin
      errors++; $display("FAIL timeout_early: got %b want 1", ring);
    end
    do_tick();
    asserts++;
    if (ring !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL timeout_fire: ring=%b busy=%b want 0 0", ring, busy);
    end
    set_time(6, 0, 0);
    do_tick();
    snooze = 1'b1; dismiss = 1'b1;
    step();
    asserts++;
    if (busy !== 1'b0 || snooze_count !== 2'd0 || ring !== 1'b0) begin
      errors++; $display("FAIL snooze_and_dismiss: busy=%b cnt=%0d ring=%b want 0 0 0",
                         busy, snooze_count, ring);
    end
  endtask

  task automatic test_bad_writes();
    do_write(1, 24, 0, 1'b1);
    asserts++;
    if (armed_mask !== 4'b1101) begin
      errors++; $display("FAIL bad_hours: mask=%b want 1101", armed_mask);
    end
    do_write(1, 5, 60, 1'b1);
    asserts++;
    if (armed_mask !== 4'b1101) begin
      errors++; $display("FAIL bad_minutes: mask=%b want 1101", armed_mask);
    end
    set_time(6, 0, 0);
    do_tick();
    snooze = 1'b1;
    step();
    do_write(0, 6, 0, 1'b0);
    asserts++;
    if (busy !== 1'b0 || ring_idx !== 2'd0 || armed_mask !== 4'b1100) begin
      errors++; $display("FAIL disarm_active: busy=%b idx=%0d mask=%b want 0 0 1100",
                         busy, ring_idx, armed_mask);
    end
  endtask

  task automatic test_adjust_and_rst();
    adjust_mode = 1'b1;
    set_time(6, 0, 0);
    do_tick();
    asserts++;
    if (ring !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL adjust_block: ring=%b busy=%b want 0 0", ring, busy);
    end
    adjust_mode = 1'b0;
    do_tick();
    asserts++;
    if (ring !== 1'b1 || ring_idx !== 2'd3) begin
      errors++; $display("FAIL adjust_release: ring=%b idx=%0d want 1 3", ring, ring_idx);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    asserts++;
    if (dut_vec !== 11'd0) begin
      errors++; $display("FAIL rst_ringing: got %h want 000", dut_vec);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 4000; c++) begin
      rst         = ($urandom_range(0, 499) == 0);
      tick_sec    = ($urandom_range(0, 1) == 1);
      adjust_mode = ($urandom_range(0, 7) == 0);
      snooze      = ($urandom_range(0, 149) == 0);
      dismiss     = ($urandom_range(0, 299) == 0);
      wr_en       = ($urandom_range(0, 19) == 0);
      wr_idx      = IDX_W'($urandom_range(0, NUM_ALARMS - 1));
      wr_hours    = ($urandom_range(0, 9) == 0) ? 5'd24 : 5'($urandom_range(6, 7));
      wr_minutes  = ($urandom_range(0, 9) == 0) ? 6'd60 : 6'($urandom_range(0, 1));
      wr_arm      = ($urandom_range(0, 3) != 0);
      set_time(int'($urandom_range(6, 7)), int'($urandom_range(0, 1)),
               ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 59)) : 0);
      step();
      asserts++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL random_c%0d: got %h want %h", c, dut_vec, exp_vec());
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_trigger_basic();
    test_lowest_index();
    test_snooze();
    test_timeout();
    test_bad_writes();
    test_adjust_and_rst();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, errors);
    $finish;
  end

endmodule
